// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller: power-up init sequence plus per-byte setup/EN/hold/exec timing.
// Optional 4-entry write FIFO in front of the FSM when LCD_HD44780_CTRL_FIFO_EN is defined.
module lcd_hd44780_ctrl #(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int INIT_EN     = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_valid_i,
  input  logic       wr_rs_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  localparam int T_MAX_A = (T_PWRUP_CYC > T_CLR_CYC) ? T_PWRUP_CYC : T_CLR_CYC;
  localparam int T_MAX_B = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
  localparam int T_MAX_C = (T_SETUP_CYC > T_HOLD_CYC) ? T_SETUP_CYC : T_HOLD_CYC;
  localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
  localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_ISSUE, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  // Counter holds cycles remaining minus one, so a zero parameter still lasts one cycle.
  function automatic logic [CW-1:0] ld(input int t);
    ld = (t <= 1) ? '0 : CW'(t - 1);
  endfunction

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h01;
      default: init_rom = 8'h06;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            init_done_q, init_done_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            on_q, on_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            is_clr;

`ifdef LCD_HD44780_CTRL_FIFO_EN
  logic [8:0]      fifo_q [4];
  logic [8:0]      fifo_d [4];
  logic [1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic            push, pop;
`endif

  assign is_clr = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    on_d        = 1'b1;
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;
`ifdef LCD_HD44780_CTRL_FIFO_EN
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    push   = wr_valid_i && ready_q;
    pop    = 1'b0;
`endif
    case (state_q)
      S_PWRUP: begin
        if (INIT_EN == 0) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_INIT_ISSUE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_INIT_ISSUE: begin
        rs_d    = 1'b0;
        data_d  = init_rom(idx_q);
        state_d = S_SETUP;
        cnt_d   = ld(T_SETUP_CYC);
      end
      S_IDLE: begin
`ifdef LCD_HD44780_CTRL_FIFO_EN
        if (fcnt_q != 3'd0 && init_done_q) pop = 1'b1;
`else
        if (wr_valid_i && ready_q) begin
          rs_d    = wr_rs_i;
          data_d  = wr_data_i;
          state_d = S_SETUP;
          cnt_d   = ld(T_SETUP_CYC);
        end
`endif
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          en_d    = 1'b1;
          cnt_d   = ld(T_EN_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          en_d    = 1'b0;
          cnt_d   = ld(T_HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = is_clr ? ld(T_CLR_CYC) : ld(T_CMD_CYC);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!init_done_q) begin
          if (idx_q == 2'd3) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_INIT_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
`ifdef LCD_HD44780_CTRL_FIFO_EN
          // Chain straight into the next queued byte so back-to-back bytes keep full throughput.
          if (fcnt_q != 3'd0) pop = 1'b1;
`endif
        end
      end
      default: state_d = S_PWRUP;
    endcase
`ifdef LCD_HD44780_CTRL_FIFO_EN
    if (pop) begin
      rs_d    = fifo_q[rptr_q][8];
      data_d  = fifo_q[rptr_q][7:0];
      state_d = S_SETUP;
      cnt_d   = ld(T_SETUP_CYC);
      rptr_d  = rptr_q + 2'd1;
    end
    if (push) begin
      fifo_d[wptr_q] = {wr_rs_i, wr_data_i};
      wptr_d         = wptr_q + 2'd1;
    end
    fcnt_d  = fcnt_q + {2'b00, push} - {2'b00, pop};
    ready_d = (fcnt_d != 3'd4);
`else
    ready_d = (state_d == S_IDLE) && init_done_d;
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_PWRUP;
      cnt_q       <= ld(T_PWRUP_CYC);
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
`ifdef LCD_HD44780_CTRL_FIFO_EN
      fifo_q      <= '{default: '0};
      wptr_q      <= 2'd0;
      rptr_q      <= 2'd0;
      fcnt_q      <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      on_q        <= on_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
`ifdef LCD_HD44780_CTRL_FIFO_EN
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
`endif
    end
  end

  assign wr_ready_o  = ready_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: init sequence, byte timing, clear/home waits, busy-time writes, reset mid-pulse.
module tb_lcd_hd44780_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_valid_i = 1'b0;
  logic       wr_rs_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       wr_ready_o, busy_o, init_done_o;
  logic       lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
  logic [7:0] lcd_data_o;

  int vecs = 0;
  int errs = 0;
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .T_PWRUP_CYC(100), .T_SETUP_CYC(2), .T_EN_CYC(5), .T_HOLD_CYC(2),
    .T_CMD_CYC(20), .T_CLR_CYC(50), .INIT_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_valid_i(wr_valid_i), .wr_rs_i(wr_rs_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .busy_o(busy_o), .init_done_o(init_done_o),
    .lcd_on_o(lcd_on_o), .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o),
    .lcd_rw_o(lcd_rw_o), .lcd_data_o(lcd_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input logic v, input int budget, output int n);
    n = 0;
    while (lcd_en_o !== v && n < budget) begin
      step();
      n++;
    end
    chk("en_reached", {31'd0, lcd_en_o}, {31'd0, v});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, {31'd0, wr_ready_o}, 0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 0);
    chk({tag, "_init_done"}, {31'd0, init_done_o}, 0);
    chk({tag, "_on"}, {31'd0, lcd_on_o}, 0);
    chk({tag, "_en"}, {31'd0, lcd_en_o}, 0);
    chk({tag, "_rs"}, {31'd0, lcd_rs_o}, 0);
    chk({tag, "_rw"}, {31'd0, lcd_rw_o}, 0);
    chk({tag, "_data"}, {24'd0, lcd_data_o}, 0);
  endtask

  // Gap = EN fall to next EN rise: hold 2 + wait + issue 1 + setup 2.
  task automatic run_init(input int first_gap, input logic exp_ready);
    int n;
    for (int i = 0; i < 4; i++) begin
      wait_en(1'b1, 300, n);
      chk($sformatf("init%0d_gap", i), n, (i == 0) ? first_gap : ((i == 3) ? 55 : 25));
      chk($sformatf("init%0d_data", i), {24'd0, lcd_data_o}, {24'd0, rom[i]});
      chk($sformatf("init%0d_rs", i), {31'd0, lcd_rs_o}, 0);
      chk($sformatf("init%0d_on", i), {31'd0, lcd_on_o}, 1);
      wait_en(1'b0, 50, n);
      chk($sformatf("init%0d_width", i), n, 5);
    end
    n = 0;
    while (init_done_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("init_done_delay", n, 22);
    chk("init_ready", {31'd0, wr_ready_o}, {31'd0, exp_ready});
    chk("init_busy", {31'd0, busy_o}, 0);
  endtask

`ifndef LCD_HD44780_CTRL_FIFO_EN
  task automatic send_byte(input string tag, input logic rs, input logic [7:0] d,
                           input int exp_total, input bit spam);
    int t, rise, high, pulses;
    logic prev;
    bit stable;
    wr_rs_i = rs; wr_data_i = d; wr_valid_i = 1'b1;
    step();
    wr_valid_i = spam;
    wr_rs_i = ~rs;
    wr_data_i = d ^ 8'hFF;
    chk({tag, "_rs"}, {31'd0, lcd_rs_o}, {31'd0, rs});
    chk({tag, "_data"}, {24'd0, lcd_data_o}, {24'd0, d});
    chk({tag, "_ready_drop"}, {31'd0, wr_ready_o}, 0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 1);
    t = 0; rise = -1; high = 0; pulses = 0; prev = lcd_en_o; stable = 1'b1;
    while (wr_ready_o !== 1'b1 && t < 1000) begin
      step();
      t++;
      if (spam) wr_data_i = 8'($urandom);
      if (lcd_en_o === 1'b1 && prev !== 1'b1) begin
        pulses++;
        if (rise < 0) rise = t;
      end
      if (lcd_en_o === 1'b1) high++;
      prev = lcd_en_o;
      if (lcd_rs_o !== rs || lcd_data_o !== d) stable = 1'b0;
    end
    wr_valid_i = 1'b0;
    chk({tag, "_total"}, t, exp_total);
    chk({tag, "_rise"}, rise, 2);
    chk({tag, "_width"}, high, 5);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_stable"}, {31'd0, stable}, 1);
  endtask
`endif

  initial begin
    int n;
    rst_i = 1'b1;
    repeat (3) step();
    check_reset("reset");
    rst_i = 1'b0;
`ifdef LCD_HD44780_CTRL_FIFO_EN
    step(); step();
    chk("fifo_ready_pwrup", {31'd0, wr_ready_o}, 1);
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1; wr_rs_i = 1'b1; wr_data_i = 8'h30 + 8'(i);
      step();
      chk($sformatf("fifo_push%0d_ready", i), {31'd0, wr_ready_o}, (i < 3) ? 1 : 0);
    end
    wr_valid_i = 1'b0;
    run_init(96, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int m;
      wait_en(1'b1, 100, n);
      chk($sformatf("fifo_byte%0d_data", i), {24'd0, lcd_data_o}, 32'h30 + i);
      chk($sformatf("fifo_byte%0d_rs", i), {31'd0, lcd_rs_o}, 1);
      if (i == 0) chk("fifo_first_rise", n, 3);
      else chk($sformatf("fifo_byte%0d_spacing", i), n + m, 29);
      wait_en(1'b0, 50, m);
    end
`else
    run_init(103, 1'b1);
    send_byte("char_41", 1'b1, 8'h41, 29, 1'b0);
    send_byte("home_02", 1'b0, 8'h02, 59, 1'b0);
    send_byte("char_01", 1'b1, 8'h01, 29, 1'b0);
    send_byte("clr_01", 1'b0, 8'h01, 59, 1'b0);
    send_byte("busy_spam", 1'b1, 8'h55, 29, 1'b1);
    // Reset during the third EN-high cycle.
    wr_valid_i = 1'b1; wr_rs_i = 1'b1; wr_data_i = 8'h7E;
    step();
    wr_valid_i = 1'b0;
    step(); step();
    chk("midpulse_en_first", {31'd0, lcd_en_o}, 1);
    step(); step();
    chk("midpulse_en_third", {31'd0, lcd_en_o}, 1);
    rst_i = 1'b1;
    step();
    check_reset("midpulse_reset");
    rst_i = 1'b0;
    run_init(103, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
